race_mac_sequencer: RTL and testbench

- Cycle-level controller for the RACE adaptive complex filter datapath.
- Once per sample strobe it sequences one shared complex MAC in four steps: delay-line shift, TAPS filter MACs, error latch, and TAPS coefficient updates.
- Sits between the clock_divider strobe and the RACE datapath. It owns the tap address, MAC control and valid_out generation.

---
 rtl/race_mac_sequencer.sv | 159 +++++++++++++++
 tb/tb_race_mac_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/race_mac_sequencer.sv
// race_mac_sequencer: per-sample controller for the RACE complex filter MAC.
// Sequences SHIFT, TAPS filter MACs, ERR latch and optional TAPS coefficient
// updates on each rising edge of the sample strobe.
// Optional build macro RACE_SEQ_WARMUP_EN: suppresses valid_out until TAPS
// frames have passed the ERR step since reset.
module race_mac_sequencer #(
  parameter int TAPS = 8,
  parameter int AW   = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          strobe,
  input  logic          valid_in,
  input  logic          adapt,
  output logic          shift_en,
  output logic [AW-1:0] tap_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          err_latch,
  output logic          upd_en,
  output logic          valid_out,
  output logic          busy,
  output logic          overrun
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    FILT  = 3'd2,
    ERR   = 3'd3,
    UPD   = 3'd4
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          strobe_d;
  logic          strobe_rise;

  logic          shift_nx, mac_clr_nx, mac_en_nx, err_nx, upd_nx;
  logic          valid_nx, busy_nx, overrun_nx;
  logic [AW-1:0] tap_nx;
  logic          warm_ok;

`ifdef RACE_SEQ_WARMUP_EN
  localparam int FW = $clog2(TAPS + 1);
  localparam logic [FW-1:0] FMAX = FW'(TAPS);

  logic [FW-1:0] frames, frames_nx;

  // Saturating count of frames that reached ERR since reset
  always_comb begin
    frames_nx = frames;
    if (state == ERR && frames != FMAX)
      frames_nx = frames + 1'b1;
  end

  // Warm-up frame counter register
  always_ff @(posedge clk) begin
    if (rst) frames <= '0;
    else     frames <= frames_nx;
  end

  assign warm_ok = (frames_nx == FMAX);
`else
  assign warm_ok = 1'b1;
`endif

  assign strobe_rise = strobe & ~strobe_d;

  // Next state, tap counter and next values of the registered outputs
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    valid_nx   = valid_out;
    overrun_nx = overrun | (strobe_rise & (state != IDLE));

    unique case (state)
      IDLE: begin
        if (strobe_rise) begin
          if (valid_in) state_nx = SHIFT;
          else          valid_nx = 1'b0;
        end
      end
      SHIFT: begin
        state_nx = FILT;
        cnt_nx   = '0;
      end
      FILT: begin
        if (cnt == LAST) begin
          state_nx = ERR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ERR: begin
        valid_nx = warm_ok;
        cnt_nx   = '0;
        state_nx = adapt ? UPD : IDLE;
      end
      UPD: begin
        if (cnt == LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    // Outputs are decoded from the upcoming state so that, once registered,
    // they line up with the state they belong to.
    shift_nx   = (state_nx == SHIFT);
    mac_en_nx  = (state_nx == FILT);
    mac_clr_nx = (state_nx == FILT) && (cnt_nx == '0);
    err_nx     = (state_nx == ERR);
    upd_nx     = (state_nx == UPD);
    busy_nx    = (state_nx != IDLE);
    tap_nx     = (state_nx == FILT || state_nx == UPD) ? cnt_nx : '0;
  end

  // State, counter, strobe history and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      strobe_d  <= 1'b0;
      shift_en  <= 1'b0;
      tap_addr  <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      err_latch <= 1'b0;
      upd_en    <= 1'b0;
      valid_out <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      strobe_d  <= strobe;
      shift_en  <= shift_nx;
      tap_addr  <= tap_nx;
      mac_clr   <= mac_clr_nx;
      mac_en    <= mac_en_nx;
      err_latch <= err_nx;
      upd_en    <= upd_nx;
      valid_out <= valid_nx;
      busy      <= busy_nx;
      overrun   <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_race_mac_sequencer.sv
// Testbench for race_mac_sequencer: randomized strobe/valid/adapt/reset
// stimulus, a frame-phase reference model feeding a scoreboard queue, and a
// monitor comparing every cycle's outputs against the queue.
module tb_race_mac_sequencer;
  localparam int TAPS = 8;
  localparam int AW   = 3;
  localparam int VW   = AW + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          strobe = 1'b0;
  logic          valid_in = 1'b0;
  logic          adapt = 1'b0;
  logic          shift_en, mac_clr, mac_en, err_latch, upd_en;
  logic          valid_out, busy, overrun;
  logic [AW-1:0] tap_addr;

  int tests = 0;
  int fails = 0;
  logic [VW-1:0] expq[$];

  always #5 clk = ~clk;

  race_mac_sequencer #(.TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .valid_in(valid_in), .adapt(adapt),
    .shift_en(shift_en), .tap_addr(tap_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .err_latch(err_latch), .upd_en(upd_en), .valid_out(valid_out), .busy(busy),
    .overrun(overrun)
  );

  // Reference model: a frame is a run of phases counted from the strobe edge.
  // Phase 1 shift, 2..TAPS+1 filter, TAPS+2 error, TAPS+3..2*TAPS+2 update.
  bit m_active = 0, m_prev = 0, m_valid = 0, m_ovr = 0;
  int m_phase = 0;
  int m_frames = 0;

  always @(posedge clk) begin : model
    bit            rise, sh, mac, clr, er, up;
    logic [AW-1:0] tap;
    if (rst) begin
      m_active = 0; m_prev = 0; m_valid = 0; m_ovr = 0; m_phase = 0; m_frames = 0;
    end else begin
      rise   = strobe && !m_prev;
      m_prev = strobe;
      if (m_active) begin
        if (rise) m_ovr = 1;
        if (m_phase == TAPS + 2) begin
          if (m_frames < TAPS) m_frames++;
`ifdef RACE_SEQ_WARMUP_EN
          m_valid = (m_frames >= TAPS);
`else
          m_valid = 1;
`endif
          if (adapt) m_phase++;
          else       m_active = 0;
        end else if (m_phase == 2 * TAPS + 2) begin
          m_active = 0;
        end else begin
          m_phase++;
        end
      end else if (rise) begin
        if (valid_in) begin
          m_active = 1;
          m_phase  = 1;
        end else begin
          m_valid = 0;
        end
      end
    end
    sh  = m_active && m_phase == 1;
    mac = m_active && m_phase >= 2 && m_phase <= TAPS + 1;
    clr = mac && m_phase == 2;
    er  = m_active && m_phase == TAPS + 2;
    up  = m_active && m_phase >= TAPS + 3;
    tap = mac ? AW'(m_phase - 2) : (up ? AW'(m_phase - TAPS - 3) : '0);
    expq.push_back({sh, tap, clr, mac, er, up, m_valid, m_active, m_ovr});
  end

  // Monitor: pops one expected output vector per registered DUT cycle
  initial begin : monitor
    logic [VW-1:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      #1;
      got_v = {shift_en, tap_addr, mac_clr, mac_en, err_latch, upd_en,
               valid_out, busy, overrun};
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty t=%0t got=%b required=an expected entry", $time, got_v);
      end else begin
        exp_v = expq.pop_front();
        if (got_v !== exp_v) begin
          fails++;
          $display("FAIL outputs t=%0t got=%b required=%b (shift,tap,clr,mac,err,upd,valid,busy,ovr)",
                   $time, got_v, exp_v);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int period, input int high, input bit v, input bit a,
                       input int rst_at);
    for (int i = 0; i < period; i++) begin
      strobe   = (i < high);
      valid_in = v;
      adapt    = a;
      rst      = (i == rst_at);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  initial begin : stimulus
    int period, high, rst_at;
    bit v, a;
    // Reset held with strobe toggling, released with strobe low
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe = i[0];
      @(negedge clk);
    end
    rst = 1'b0; strobe = 1'b0;
    step(5);
    // Nominal frames: divide-by-20, adapt on
    repeat (100) frame(20, 10, 1'b1, 1'b1, -1);
    // No adaptation
    repeat (5) frame(20, 10, 1'b1, 1'b0, -1);
    // Invalid edge with a long gap, then resume
    frame(200, 10, 1'b0, 1'b1, -1);
    repeat (2) frame(20, 10, 1'b1, 1'b1, -1);
    // Overrun with a 10-clk strobe period, then held until reset
    repeat (6) frame(10, 5, 1'b1, 1'b1, -1);
    repeat (3) frame(25, 5, 1'b1, 1'b1, -1);
    rst = 1'b1; step(1); rst = 1'b0;
    // Reset in the middle of filtering
    strobe = 1'b1; valid_in = 1'b1; adapt = 1'b1;
    step(5);
    rst = 1'b1; step(1); rst = 1'b0; strobe = 1'b0;
    step(5);
    frame(25, 10, 1'b1, 1'b1, -1);
    // Strobe already high when reset releases
    rst = 1'b1; strobe = 1'b1; step(2);
    rst = 1'b0; step(25);
    strobe = 1'b0; step(3);
    // Randomized frames including short periods and sporadic resets
    repeat (300) begin
      period = $urandom_range(30, 8);
      high   = $urandom_range(period - 1, 1);
      v      = ($urandom_range(4, 0) != 0);
      a      = 1'($urandom_range(1, 0));
      rst_at = ($urandom_range(24, 0) == 0) ? $urandom_range(period - 1, 0) : -1;
      frame(period, high, v, a, rst_at);
    end
    strobe = 1'b0;
    step(30);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d entries required=0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
